// File: rtl/e3_serial_sub.sv
// e3_serial_sub: digit-serial Excess-3 BCD subtractor, z = x - y - bi.
// One E3 digit is handled per clock, least-significant digit first, under a
// start/busy/done handshake. The result, borrow-out and invalid-digit flag
// are published together on the cycle that done is high, and then held.
module e3_serial_sub #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   x,
    input  logic [4*DIGITS-1:0]   y,
    input  logic                  bi,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   z,
    output logic                  bo,
    output logic                  err
);

    // The digit index needs at least one bit, even when DIGITS is 1.
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Operand copies taken at accept, so x/y/bi may change during RUN.
    logic [4*DIGITS-1:0] xs_reg;
    logic [4*DIGITS-1:0] ys_reg;
    logic [4*DIGITS-1:0] res_reg;
    logic [4*DIGITS-1:0] res_next;
    logic [IW-1:0]       idx_reg;
    logic                borrow_reg;
    logic                err_acc_reg;

    // Published outputs; they change only on completion or reset.
    logic [4*DIGITS-1:0] z_reg;
    logic                bo_reg;
    logic                err_reg;

    // Per-digit views of the operand registers for the idx-selected digit.
    logic [3:0] xd [DIGITS];
    logic [3:0] yd [DIGITS];

    logic [3:0] x_dig;
    logic [3:0] y_dig;
    logic [5:0] diff;
    logic       diff_neg;
    logic [3:0] z_dig;
    logic       dig_bad;
    logic       last_dig;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign xd[gi] = xs_reg[4*gi +: 4];
            assign yd[gi] = ys_reg[4*gi +: 4];
            // Only the digit currently being processed is overwritten.
            assign res_next[4*gi +: 4] = (idx_reg == IW'(gi)) ? z_dig : res_reg[4*gi +: 4];
        end
    endgenerate

    // Per-digit E3 subtraction: a negative difference wraps by adding ten
    // (13 = 10 + 3 excess), a non-negative one just restores the excess 3.
    always_comb begin
        x_dig    = xd[idx_reg];
        y_dig    = yd[idx_reg];
        diff     = {2'b00, x_dig} - {2'b00, y_dig} - {5'b00000, borrow_reg};
        diff_neg = diff[5];
        z_dig    = diff_neg ? (diff[3:0] + 4'd13) : (diff[3:0] + 4'd3);
        dig_bad  = (x_dig < 4'h3) || (x_dig > 4'hC) || (y_dig < 4'h3) || (y_dig > 4'hC);
        last_dig = (idx_reg == LAST_IDX);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: start is honoured only in IDLE; DONE lasts one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_dig) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: capture at accept, one digit per RUN cycle, publish on the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            xs_reg      <= '0;
            ys_reg      <= '0;
            res_reg     <= '0;
            idx_reg     <= '0;
            borrow_reg  <= 1'b0;
            err_acc_reg <= 1'b0;
            z_reg       <= '0;
            bo_reg      <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        xs_reg      <= x;
                        ys_reg      <= y;
                        borrow_reg  <= bi;
                        err_acc_reg <= 1'b0;
                        idx_reg     <= '0;
                        res_reg     <= '0;
                    end
                end
                S_RUN: begin
                    res_reg     <= res_next;
                    borrow_reg  <= diff_neg;
                    err_acc_reg <= err_acc_reg | dig_bad;
                    if (last_dig) begin
                        idx_reg <= '0;
                        z_reg   <= res_next;
                        bo_reg  <= diff_neg;
                        err_reg <= err_acc_reg | dig_bad;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign z   = z_reg;
    assign bo  = bo_reg;
    assign err = err_reg;

endmodule
